// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller: default operand
// width and the FSM state encoding.
package mult_pkg;

  localparam int WIDTH_DEF = 4;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LOAD  = 3'd1;
  localparam state_t ADD   = 3'd2;
  localparam state_t SHIFT = 3'd3;
  localparam state_t DONE  = 3'd4;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the shift-add loop; clear has priority over inc.
module iter_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mult_controller.sv
// Moore FSM sequencing a WIDTH-iteration shift-add multiplier datapath.
// add_en is the only output that also depends on an input (q0).
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  output logic load,
  output logic clr_p,
  output logic add_en,
  output logic shift_en,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic            cnt_clear;
  logic            cnt_inc;

  iter_counter #(.CW(CW)) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start is only looked at in IDLE, so requests while busy are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (count == LAST_ITER) ? DONE : ADD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_clear = (state == LOAD);
  assign cnt_inc   = (state == SHIFT);

  always_comb begin
    load     = 1'b0;
    clr_p    = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        load  = 1'b1;
        clr_p = 1'b1;
        busy  = 1'b1;
      end
      ADD: begin
        add_en = q0;
        busy   = 1'b1;
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller: a shift-add datapath model feeds q0,
// and each cycle's control outputs are compared against a per-operation schedule.
module tb_mult_controller;

  localparam int W   = 4;
  localparam int OPC = 2 * W + 3;  // LOAD, W x (ADD, SHIFT), DONE, one IDLE

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic q0;
  logic load, clr_p, add_en, shift_en, busy, done;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [5:0]     exp_q[$];
  logic [W-1:0]   a_op, b_op, a_reg;
  logic [2*W:0]   p = '0;

  mult_controller #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .q0       (q0),
    .load     (load),
    .clr_p    (clr_p),
    .add_en   (add_en),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  // clock
  always #5 clk = ~clk;

  // datapath model: product/multiplier register with carry bit on top
  assign q0 = p[0];
  always @(posedge clk) begin
    if (load) begin
      a_reg <= a_op;
      p     <= {(W + 1)'(0), b_op};
    end else if (add_en) begin
      p[2*W:W] <= p[2*W:W] + {1'b0, a_reg};
    end else if (shift_en) begin
      p <= p >> 1;
    end
  end

  // expected {load, clr_p, add_en, shift_en, busy, done} for cycle c of an op
  function automatic logic [5:0] exp_vec(input int c, input logic [W-1:0] b);
    logic [5:0] v;
    v = 6'b000000;
    if (c == 1)                         v = 6'b110010;
    else if (c >= 2 && c <= 2 * W && (c % 2) == 0)
      v = {2'b00, b[(c - 2) / 2], 3'b010};
    else if (c >= 3 && c <= 2 * W + 1) v = 6'b000110;
    else if (c == 2 * W + 2)            v = 6'b000011;
    return v;
  endfunction

  task automatic check_vec(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {load, clr_p, add_en, shift_en, busy, done};
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_next(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      checks_total++;
      $error("FAIL %s: observed empty expected queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_vec(tag, e);
    end
  endtask

  task automatic check_prod(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] exp;
    exp = (2 * W)'(a) * (2 * W)'(b);
    checks_total++;
    assert (p[2*W-1:0] === exp) checks_passed++;
    else $error("FAIL %s: observed product %0d expected %0d", tag, p[2*W-1:0], exp);
  endtask

  // one operation; optional start pulses in cycles 3 and 6 must be ignored
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ign);
    a_op = a;
    b_op = b;
    for (int c = 1; c <= OPC; c++) exp_q.push_back(exp_vec(c, b));
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= OPC; c++) begin
      @(negedge clk);
      start = ign && (c == 3 || c == 6);
      check_next(tag);
      if (c == 2 * W + 2) check_prod(tag, a, b);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_op  = '0;
    b_op  = '0;

    // reset
    @(negedge clk);
    check_vec("reset_hold", 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_vec("reset_idle", 6'b000000);
    end

    // directed patterns
    run_op("f_times_f", 4'hF, 4'hF, 1'b0);
    run_op("six_times_ten", 4'd6, 4'b1010, 1'b0);
    run_op("ignored_start", 4'd9, 4'd13, 1'b1);

    // abort in cycle 5, then a fresh operation
    a_op = 4'd7;
    b_op = 4'd5;
    for (int c = 1; c <= 5; c++) exp_q.push_back(exp_vec(c, b_op));
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_next("abort_pre");
    end
    #2 rst = 1'b1;
    #1 check_vec("abort_async", 6'b000000);
    @(negedge clk);
    check_vec("abort_hold", 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_vec("abort_no_done", 6'b000000);
    end
    run_op("after_abort", 4'd7, 4'd5, 1'b0);

    // randomized operations
    for (int n = 0; n < 6; n++) begin
      run_op("random_op", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
    end

    // back-to-back with start held high: period OPC, one IDLE cycle between
    a_op = 4'd11;
    b_op = 4'd3;
    for (int k = 0; k < 3; k++)
      for (int c = 1; c <= OPC; c++) exp_q.push_back(exp_vec(c, b_op));
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 3 * OPC; c++) begin
      @(negedge clk);
      if (c == 3 * OPC) start = 1'b0;
      check_next("back_to_back");
      if ((c % OPC) == 2 * W + 2) check_prod("back_to_back", 4'd11, 4'd3);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("final_idle", 6'b000000);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
